// File: rtl/gray_seq_gen_if.sv
// Handshake bundle for the Gray sequence generator.
// The master drives the start, configuration and ready signals; the slave returns the code stream and status.
interface gray_seq_gen_if #(
    parameter int unsigned N = 4
);
    logic         start;
    logic         dir;
    logic [N-1:0] start_val;
    logic [N-1:0] len;
    logic         ready;
    logic [N-1:0] gray_out;
    logic         valid;
    logic         busy;
    logic         done;

    modport master (
        output start, dir, start_val, len, ready,
        input  gray_out, valid, busy, done
    );

    modport slave (
        input  start, dir, start_val, len, ready,
        output gray_out, valid, busy, done
    );
endinterface

// File: rtl/gray_seq_gen.sv
// Emits len+1 consecutive Gray codes from a binary seed, counting up or down.
// Uses a valid/ready handshake; done pulses for one cycle once the last word is taken.
module gray_seq_gen #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    gray_seq_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] bin_cnt_q, bin_cnt_d;
    logic [N-1:0] remaining_q, remaining_d;
    logic [N-1:0] gray_out_q, gray_out_d;
    logic         dir_q, dir_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [N-1:0] bin_next_c;

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Next count is modulo 2^N, so wrap-around needs no special case
    always_comb begin
        bin_next_c = dir_q ? (bin_cnt_q - N'(1)) : (bin_cnt_q + N'(1));
    end

    always_comb begin
        state_d     = state_q;
        bin_cnt_d   = bin_cnt_q;
        remaining_d = remaining_q;
        gray_out_d  = gray_out_q;
        dir_d       = dir_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    bin_cnt_d   = bus.start_val;
                    remaining_d = bus.len;
                    dir_d       = bus.dir;
                    gray_out_d  = to_gray(bus.start_val);
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            RUN: begin
                // Without a transfer everything holds, which freezes the word under backpressure
                if (valid_q && bus.ready) begin
                    if (remaining_q != '0) begin
                        bin_cnt_d   = bin_next_c;
                        remaining_d = remaining_q - N'(1);
                        gray_out_d  = to_gray(bin_next_c);
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_cnt_q   <= '0;
            remaining_q <= '0;
            gray_out_q  <= '0;
            dir_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_cnt_q   <= bin_cnt_d;
            remaining_q <= remaining_d;
            gray_out_q  <= gray_out_d;
            dir_q       <= dir_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.gray_out = gray_out_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed self-checking bench for gray_seq_gen with N=4.
module tb_gray_seq_gen;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gray_seq_gen_if #(.N(4)) bus ();

    gray_seq_gen #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; afterwards the first word should be on gray_out
    task automatic start_seq(input logic [3:0] sv, input logic [3:0] l, input logic d);
        bus.start     = 1'b1;
        bus.start_val = sv;
        bus.len       = l;
        bus.dir       = d;
        step();
        bus.start     = 1'b0;
    endtask

    // Record valid words with ready high until done is seen; ends in the DONE cycle
    task automatic collect(input int budget, output int n, output logic [3:0] w [0:15],
                           output int ndone, output int gaps, output bit finished);
        n = 0; ndone = 0; gaps = 0; finished = 1'b0;
        for (int i = 0; i < 16; i++) w[i] = '0;
        bus.ready = 1'b1;
        for (int c = 0; c < budget && !finished; c++) begin
            if (bus.done) begin
                ndone++;
                finished = 1'b1;
            end else begin
                if (bus.valid && n < 16) begin
                    w[n] = bus.gray_out;
                    n++;
                end else if (!bus.valid) begin
                    gaps++;
                end
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1; bus.start_val = 4'd7; bus.len = 4'd3; bus.dir = 1'b0; bus.ready = 1'b1;
        step();
        step();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", bus.valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d exp 0", bus.done); end
        checks++; if (bus.gray_out !== 4'd0) begin errors++; $display("FAIL reset_gray got %0d exp 0", bus.gray_out); end
        bus.start = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [3:0] w [0:15];
        logic [3:0] exp_w [0:3];
        int n, nd, gaps;
        bit fin;
        exp_w = '{4'd0, 4'd1, 4'd3, 4'd2};
        start_seq(4'd0, 4'd3, 1'b0);
        checks++; if (bus.valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_latency got valid=%0d busy=%0d exp 1 1", bus.valid, bus.busy); end
        collect(40, n, w, nd, gaps, fin);
        checks++; if (!fin || n != 4) begin errors++; $display("FAIL basic_count got %0d fin=%0d exp 4", n, fin); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== exp_w[i]) begin errors++; $display("FAIL basic_word%0d got %0d exp %0d", i, w[i], exp_w[i]); end
        end
        checks++; if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_done_state got valid=%0d busy=%0d exp 0 1", bus.valid, bus.busy); end
        step();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle got done=%0d busy=%0d exp 0 0", bus.done, bus.busy); end
        checks++; if (bus.gray_out !== 4'd2) begin errors++; $display("FAIL basic_retain got %0d exp 2", bus.gray_out); end
        step();
    endtask

    task automatic test_up_wrap();
        logic [3:0] w [0:15];
        logic [3:0] exp_w [0:3];
        int n, nd, gaps;
        bit fin;
        exp_w = '{4'd9, 4'd8, 4'd0, 4'd1};
        start_seq(4'd14, 4'd3, 1'b0);
        collect(40, n, w, nd, gaps, fin);
        checks++; if (!fin || n != 4 || gaps != 0) begin errors++; $display("FAIL upwrap_count got n=%0d gaps=%0d exp 4 0", n, gaps); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== exp_w[i]) begin errors++; $display("FAIL upwrap_word%0d got %0d exp %0d", i, w[i], exp_w[i]); end
        end
        step();
        step();
    endtask

    task automatic test_down_wrap();
        logic [3:0] w [0:15];
        logic [3:0] exp_w [0:2];
        int n, nd, gaps;
        bit fin;
        exp_w = '{4'd1, 4'd0, 4'd8};
        start_seq(4'd1, 4'd2, 1'b1);
        collect(40, n, w, nd, gaps, fin);
        checks++; if (!fin || n != 3 || nd != 1) begin errors++; $display("FAIL downwrap_count got n=%0d done=%0d exp 3 1", n, nd); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (w[i] !== exp_w[i]) begin errors++; $display("FAIL downwrap_word%0d got %0d exp %0d", i, w[i], exp_w[i]); end
        end
        step();
        step();
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_w [0:3];
        logic [3:0] got [0:3];
        int xfers, hold;
        bit fin;
        exp_w = '{4'd0, 4'd1, 4'd3, 4'd2};
        got   = '{4'd0, 4'd0, 4'd0, 4'd0};
        xfers = 0; hold = 0; fin = 1'b0;
        start_seq(4'd0, 4'd3, 1'b0);
        for (int c = 0; c < 40 && !fin; c++) begin
            if (bus.done) begin
                fin = 1'b1;
            end else begin
                if (bus.valid && bus.gray_out == 4'd3 && hold < 3) begin
                    bus.ready = 1'b0;
                    hold++;
                    checks++;
                    if (bus.valid !== 1'b1 || bus.gray_out !== 4'd3) begin
                        errors++; $display("FAIL bp_hold%0d got valid=%0d gray=%0d exp 1 3", hold, bus.valid, bus.gray_out);
                    end
                end else begin
                    bus.ready = 1'b1;
                end
                if (bus.valid && bus.ready) begin
                    if (xfers < 4) got[xfers] = bus.gray_out;
                    xfers++;
                end
                step();
            end
        end
        bus.ready = 1'b1;
        checks++; if (!fin || xfers != 4 || hold != 3) begin errors++; $display("FAIL bp_xfers got %0d hold=%0d fin=%0d exp 4 3 1", xfers, hold, fin); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL bp_word%0d got %0d exp %0d", i, got[i], exp_w[i]); end
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        logic [3:0] w [0:15];
        int n, nd, gaps, bad;
        bit fin;
        bus.ready = 1'b1;
        start_seq(4'd0, 4'd7, 1'b0);
        step();
        step();
        checks++; if (bus.gray_out !== 4'd3) begin errors++; $display("FAIL rmid_pre got %0d exp 3", bus.gray_out); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.gray_out !== 4'd0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL rmid_after got valid=%0d busy=%0d gray=%0d done=%0d exp 0 0 0 0", bus.valid, bus.busy, bus.gray_out, bus.done);
        end
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.valid || bus.done) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rmid_quiet got %0d exp 0", bad); end
        start_seq(4'd5, 4'd0, 1'b0);
        checks++; if (bus.valid !== 1'b1 || bus.gray_out !== 4'd7) begin errors++; $display("FAIL rmid_restart got valid=%0d gray=%0d exp 1 7", bus.valid, bus.gray_out); end
        collect(20, n, w, nd, gaps, fin);
        checks++; if (!fin || n != 1) begin errors++; $display("FAIL rmid_single got %0d exp 1", n); end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] w [0:15];
        int n, nd, gaps;
        bit fin;
        start_seq(4'd3, 4'd0, 1'b0);
        collect(20, n, w, nd, gaps, fin);
        checks++; if (!fin) begin errors++; $display("FAIL b2b_first got fin=%0d exp 1", fin); end
        bus.start = 1'b1; bus.start_val = 4'd6; bus.len = 4'd1; bus.dir = 1'b0;
        step();
        checks++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_done_ignore got valid=%0d busy=%0d exp 0 0", bus.valid, bus.busy); end
        step();
        bus.start = 1'b0;
        checks++; if (bus.valid !== 1'b1 || bus.gray_out !== 4'd5) begin errors++; $display("FAIL b2b_accept got valid=%0d gray=%0d exp 1 5", bus.valid, bus.gray_out); end
        collect(20, n, w, nd, gaps, fin);
        checks++; if (!fin || n != 2 || w[1] !== 4'd4) begin errors++; $display("FAIL b2b_seq got n=%0d w1=%0d exp 2 4", n, w[1]); end
        step();
        step();
    endtask

    task automatic test_full_cycle();
        logic [3:0] w [0:15];
        logic [15:0] seen;
        logic [3:0] nxt;
        int n, nd, bad_adj, bad_seq;
        bit fin;
        n = 0; nd = 0; fin = 1'b0; seen = '0;
        for (int i = 0; i < 16; i++) w[i] = '0;
        bus.ready = 1'b1;
        start_seq(4'd0, 4'd15, 1'b0);
        for (int c = 0; c < 60 && !fin; c++) begin
            if (c == 5) begin
                bus.start = 1'b1; bus.start_val = 4'd9; bus.len = 4'd0; bus.dir = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                nd++;
                fin = 1'b1;
            end else begin
                if (bus.valid && n < 16) begin
                    w[n] = bus.gray_out;
                    n++;
                end
                step();
            end
        end
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) seen[w[i]] = 1'b1;
        bad_adj = 0; bad_seq = 0;
        for (int i = 0; i < 16; i++) begin
            nxt = w[(i + 1) % 16];
            if ($countones(w[i] ^ nxt) != 1) bad_adj++;
            if (w[i] !== 4'(i ^ (i >> 1))) bad_seq++;
        end
        checks++; if (!fin || n != 16 || nd != 1) begin errors++; $display("FAIL full_count got n=%0d done=%0d exp 16 1", n, nd); end
        checks++; if (seen !== 16'hFFFF) begin errors++; $display("FAIL full_distinct got %h exp ffff", seen); end
        checks++; if (bad_adj != 0) begin errors++; $display("FAIL full_adjacent got %0d exp 0", bad_adj); end
        checks++; if (bad_seq != 0) begin errors++; $display("FAIL full_order got %0d exp 0", bad_seq); end
        step();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.dir = 1'b0; bus.start_val = '0; bus.len = '0; bus.ready = 1'b1;
        test_reset();
        test_basic();
        test_up_wrap();
        test_down_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_full_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_seq_gen.md
GRAY_SEQ_GEN -- requirements
Module: gray_seq_gen

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the Gray/binary code width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin a sequence, sampled only in IDLE.
REQ-005 The block SHALL have port dir, input, 1 bit: count direction, 0 = up and 1 = down, latched on an accepted start.
REQ-006 The block SHALL have port start_val, input, N bits: the binary seed value, latched on an accepted start.
REQ-007 The block SHALL have port len, input, N bits: number of codes to emit minus 1 (range 1..2^N codes), latched on an accepted start.
REQ-008 The block SHALL have port ready, input, 1 bit: the downstream consumer (Gray-to-binary stage) can accept gray_out.
REQ-009 The block SHALL have port gray_out, output, N bits: the current Gray code word, registered.
REQ-010 The block SHALL have port valid, output, 1 bit: gray_out holds a valid word, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN and DONE, registered.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse after the last word is accepted, registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE -> RUN SHALL occur when start=1; on that edge, latch bin_cnt=start_val, remaining=len, dir_q=dir, gray_out=start_val^(start_val>>1), and valid=1.
REQ-015 Latency SHALL be one cycle: start is sampled at edge k, and valid is high with the first word after edge k.
REQ-016 Handshake: a word SHALL transfer on any edge where valid=1 and ready=1.
REQ-017 While valid=1 and ready=0, gray_out and valid SHALL be held stable; internal state SHALL be frozen.
REQ-018 On a transfer with remaining!=0: bin_cnt SHALL become bin_cnt+1 (dir_q=0) or bin_cnt-1 (dir_q=1) modulo 2^N, remaining SHALL decrement, and gray_out SHALL become the Gray code of the new bin_cnt.
REQ-019 Gray encoding SHALL be g = b XOR (b >> 1) on N bits; consecutive emitted words SHALL differ in exactly one bit, including across wrap-around.
REQ-020 Wrap-around SHALL be silent, with no flag: up from 2^N-1 goes to 0, and down from 0 goes to 2^N-1.
REQ-021 On a transfer with remaining==0, the FSM SHALL go RUN -> DONE and valid SHALL drop to 0 on the same edge.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL go DONE -> IDLE unconditionally; busy SHALL be 1 in DONE.
REQ-023 The start input SHALL be ignored in RUN and DONE; a start in the IDLE cycle immediately after DONE SHALL be accepted.
REQ-024 gray_out SHALL retain the last emitted word after the sequence ends, until the next accepted start or reset.
REQ-025 With len=2^N-1, exactly 2^N distinct codes SHALL be emitted, covering the full cycle.

Reset
REQ-026 When rst=1 at an edge, from any state including mid-transfer: the FSM SHALL go to IDLE, gray_out=0, valid=0, busy=0, done=0, bin_cnt=0 and remaining=0.
REQ-027 rst SHALL have priority over start and ready on the same edge.
REQ-028 No word SHALL be emitted after a reset until a new start is accepted.

Verification
REQ-029 N=4, start_val=0, len=3, dir=0, ready=1 -> gray_out 0,1,3,2 on four consecutive valid cycles, then done=1 for one cycle, then busy=0.
REQ-030 Up wrap: start_val=14, len=3, dir=0 -> binary 14,15,0,1 and gray_out 9,8,0,1; no glitch on valid.
REQ-031 Down wrap: start_val=1, len=2, dir=1 -> gray_out 1,0,8, then done.
REQ-032 Backpressure: start_val=0, len=3, ready low for 3 cycles while gray_out=3 -> gray_out stays 3 and valid stays 1; the sequence resumes with 2 when ready=1; total transfers = 4.
REQ-033 Reset mid-RUN, after 2 of 8 words -> next cycle: valid=0, busy=0, gray_out=0, done never pulses; a new start with start_val=5 emits 7 first.
REQ-034 Full cycle plus ignored start: len=15, start pulsed again during RUN -> exactly 16 distinct codes emitted, each adjacent pair (including 15->0) differs in one bit, and the second start has no effect.
